// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access codes, FSM encoding and width helper for the load/store unit
package lsu_pkg;
  localparam logic [3:0] MC_LD  = 4'b0000;
  localparam logic [3:0] MC_LHU = 4'b0001;
  localparam logic [3:0] MC_LBU = 4'b0010;
  localparam logic [3:0] MC_LW  = 4'b0011;
  localparam logic [3:0] MC_LH  = 4'b0100;
  localparam logic [3:0] MC_SD  = 4'b1000;
  localparam logic [3:0] MC_SB  = 4'b1001;
  localparam logic [3:0] MC_SH  = 4'b1010;
  localparam logic [3:0] MC_SW  = 4'b1011;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAULT} state_t;
  // Unshifted byte mask for the access width; 0 marks an illegal code.
  function automatic logic [7:0] size_mask(input logic [3:0] c);
    return (c == MC_LD || c == MC_SD) ? 8'hFF :
           (c == MC_LW || c == MC_SW) ? 8'h0F :
           (c == MC_LHU || c == MC_LH || c == MC_SH) ? 8'h03 :
           (c == MC_LBU || c == MC_SB) ? 8'h01 : 8'h00;
  endfunction
endpackage

// File: rtl/lsu_mem_access_if.sv
// lsu_mem_access_if: valid/ready request/response bus between the LSU and data memory
//   master (LSU): drives mem_req_valid/we/addr/wdata/wmask; samples mem_req_ready, mem_resp_valid, mem_resp_rdata
//   slave (memory): the reverse
interface lsu_mem_access_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  modport master(output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
                 input mem_req_ready, mem_resp_valid, mem_resp_rdata);
  modport slave(input mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
                output mem_req_ready, mem_resp_valid, mem_resp_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed lane of an aligned 8-byte word and sign/zero-extends it
//   code: access code, offset: addr[2:0], line: aligned read data, ext: extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [3:0]  code,
  input  logic [2:0]  offset,
  input  logic [63:0] line,
  output logic [63:0] ext
);
  logic [63:0] lane;
  assign lane = line >> {offset, 3'b000};
  always_comb
    ext = code == MC_LBU ? {56'b0, lane[7:0]} :
          code == MC_LHU ? {48'b0, lane[15:0]} :
          code == MC_LH  ? {{48{lane[15]}}, lane[15:0]} :
          code == MC_LW  ? {{32{lane[31]}}, lane[31:0]} : lane;
endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: one-access-at-a-time load/store unit between the core datapath and data memory
//   clk, rst_n (async, active low)
//   core side: core_valid/core_ready accept, mem_ctrl code, core_addr, core_wdata;
//              done pulse with err and extended rdata
//   mem: lsu_mem_access_if master (request with byte mask, response with aligned read data)
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     core_valid,
  output logic                     core_ready,
  input  logic [3:0]               mem_ctrl,
  input  logic [63:0]              core_addr,
  input  logic [63:0]              core_wdata,
  output logic                     done,
  output logic                     err,
  output logic [63:0]              rdata,
  lsu_mem_access_if.master         mem
);
  state_t state, state_nx;
  logic [3:0] code_q;
  logic [2:0] offset_q;
  logic we_q;
  logic [63:0] addr_q, wdata_q, load_val;
  logic [7:0] wmask_q, m;
  logic [CNT_W-1:0] cnt;
  logic ok, accept, timeout;
  assign m = size_mask(mem_ctrl);
  // Offset bits that must be zero for the access width: d=111, w=011, h=001, b=000.
  assign ok = (m != 8'h00) && ((core_addr[2:0] & {m[7], m[3], m[1]}) == 3'b000);
  assign accept = core_valid && core_ready;
  assign timeout = cnt == CNT_W'(TIMEOUT - 1);
  assign core_ready = state == S_IDLE;
  assign done = state == S_DONE || state == S_FAULT;
  assign err = state == S_FAULT;
  assign mem.mem_req_valid = state == S_REQ;
  assign mem.mem_req_we = we_q;
  assign mem.mem_req_addr = addr_q;
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_wmask = wmask_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = ok ? S_REQ : S_FAULT;
      S_REQ: if (mem.mem_req_ready) state_nx = S_WAIT;
      S_WAIT: state_nx = mem.mem_resp_valid ? S_DONE : timeout ? S_FAULT : S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      code_q <= '0;
      offset_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt <= '0;
      rdata <= '0;
    end else begin
      if (accept) begin
        code_q <= mem_ctrl;
        offset_q <= core_addr[2:0];
        we_q <= mem_ctrl[3];
        addr_q <= {core_addr[63:3], 3'b000};
        wdata_q <= core_wdata << {core_addr[2:0], 3'b000};
        wmask_q <= mem_ctrl[3] ? m << core_addr[2:0] : 8'h00;
        rdata <= '0;
      end
      if (state == S_REQ && mem.mem_req_ready) cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      if (state == S_WAIT && mem.mem_resp_valid) rdata <= we_q ? 64'b0 : load_val;
    end
  lsu_load_align u_align (
    .code(code_q),
    .offset(offset_q),
    .line(mem.mem_resp_rdata),
    .ext(load_val)
  );
endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access: table-driven accesses against a byte-masked memory model with request/done scoreboards
module tb_lsu_mem_access;
  import lsu_pkg::*;
  typedef struct {
    logic [3:0] code; logic [63:0] addr; logic [63:0] wdata; bit pre; logic [63:0] line;
    logic err; logic [63:0] rdata; logic we; logic [63:0] wd; logic [7:0] wm;
  } vec_t;
  typedef struct {logic we; logic [63:0] addr; logic [63:0] wd; logic [7:0] wm;} req_t;
  typedef struct {logic err; logic [63:0] rd;} done_t;
  logic clk = 0, rst_n, core_valid, core_ready, done, err;
  logic [3:0] mem_ctrl;
  logic [63:0] core_addr, core_wdata, rdata;
  lsu_mem_access_if mif();
  req_t exp_req[$];
  done_t exp_done[$];
  logic [63:0] mem_m [logic [60:0]];
  int tests = 0, fails = 0, stall = 0;
  bit silent = 0;
  vec_t v[21];
  lsu_mem_access dut (
    .clk(clk), .rst_n(rst_n), .core_valid(core_valid), .core_ready(core_ready),
    .mem_ctrl(mem_ctrl), .core_addr(core_addr), .core_wdata(core_wdata),
    .done(done), .err(err), .rdata(rdata), .mem(mif)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Memory responder: checks request fields every cycle they are offered, applies stalls,
  // commits masked stores and answers one cycle after the handshake.
  initial begin
    logic [63:0] line, wd, ad;
    logic [7:0] wm;
    logic we;
    mif.mem_req_ready = 0;
    mif.mem_resp_valid = 0;
    mif.mem_resp_rdata = 0;
    forever begin
      @(negedge clk);
      if (mif.mem_req_valid === 1'b1) begin
        if (exp_req.size() == 0) check("unexpected_req", {63'b0, mif.mem_req_valid}, 64'd0);
        else begin
          check("req_we", {63'b0, mif.mem_req_we}, {63'b0, exp_req[0].we});
          check("req_addr", mif.mem_req_addr, exp_req[0].addr);
          check("req_wdata", mif.mem_req_wdata, exp_req[0].wd);
          check("req_wmask", {56'b0, mif.mem_req_wmask}, {56'b0, exp_req[0].wm});
        end
        if (stall > 0) begin
          stall--;
          mif.mem_req_ready = 0;
        end else begin
          mif.mem_req_ready = 1;
          if (exp_req.size() != 0) void'(exp_req.pop_front());
          we = mif.mem_req_we; ad = mif.mem_req_addr; wd = mif.mem_req_wdata; wm = mif.mem_req_wmask;
          @(posedge clk);
          #1 mif.mem_req_ready = 0;
          if (!silent) begin
            line = mem_m.exists(ad[63:3]) ? mem_m[ad[63:3]] : 64'd0;
            if (we) begin
              for (int b = 0; b < 8; b++) if (wm[b]) line[8*b +: 8] = wd[8*b +: 8];
              mem_m[ad[63:3]] = line;
            end
            mif.mem_resp_rdata = line;
            mif.mem_resp_valid = 1;
            @(posedge clk);
            #1 mif.mem_resp_valid = 0;
          end
        end
      end else mif.mem_req_ready = 0;
    end
  end
  // Completion scoreboard: every done pulse must match the oldest expectation.
  initial forever begin
    done_t d;
    @(negedge clk);
    if (done === 1'b1) begin
      if (exp_done.size() == 0) check("unexpected_done", {63'b0, done}, 64'd0);
      else begin
        d = exp_done.pop_front();
        check("err", {63'b0, err}, {63'b0, d.err});
        check("rdata", rdata, d.rd);
        check("ready_in_done", {63'b0, core_ready}, 64'd0);
      end
    end
  end
  task automatic run(input vec_t t, input int lat, input bit issue, input bit wait_done);
    int n;
    if (t.pre) mem_m[t.addr[63:3]] = t.line;
    if (issue) exp_req.push_back('{t.we, {t.addr[63:3], 3'b000}, t.wd, t.wm});
    if (wait_done) exp_done.push_back('{t.err, t.rdata});
    n = 0;
    while (core_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (core_ready !== 1'b1) check("ready_timeout", {63'b0, core_ready}, 64'd1);
    core_valid = 1; mem_ctrl = t.code; core_addr = t.addr; core_wdata = t.wdata;
    @(posedge clk);
    #1 core_valid = 0;
    mem_ctrl = 4'($urandom); core_addr = {$urandom, $urandom}; core_wdata = {$urandom, $urandom};
    if (wait_done) begin
      n = 0;
      do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 400);
      check("done_seen", {63'b0, done}, 64'd1);
      if (lat > 0) check("latency", 64'(n), 64'(lat));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0; core_valid = 0; mem_ctrl = 0; core_addr = 0; core_wdata = 0;
    v[0]  = '{MC_SW,  64'h80000004, 64'hDEADBEEF, 0, 0, 0, 0, 1, 64'hDEADBEEF_00000000, 8'hF0};
    v[1]  = '{MC_LH,  64'h80000006, 0, 1, 64'h8001_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_8001, 0, 0, 0};
    v[2]  = '{MC_LHU, 64'h80000006, 0, 1, 64'h8001_0000_0000_0000, 0, 64'h8001, 0, 0, 0};
    v[3]  = '{MC_LD,  64'h80000004, 0, 0, 0, 1, 0, 0, 0, 0};
    v[4]  = '{4'b0111, 64'h80000000, 0, 0, 0, 1, 0, 0, 0, 0};
    v[5]  = '{MC_SD,  64'h80000010, 64'h0123456789ABCDEF, 0, 0, 0, 0, 1, 64'h0123456789ABCDEF, 8'hFF};
    v[6]  = '{MC_LD,  64'h80000010, 0, 0, 0, 0, 64'h0123456789ABCDEF, 0, 0, 0};
    v[7]  = '{MC_LW,  64'h80000010, 0, 0, 0, 0, 64'hFFFFFFFF89ABCDEF, 0, 0, 0};
    v[8]  = '{MC_LW,  64'h80000014, 0, 0, 0, 0, 64'h0000000001234567, 0, 0, 0};
    v[9]  = '{MC_LBU, 64'h80000017, 0, 0, 0, 0, 64'h01, 0, 0, 0};
    v[10] = '{MC_LBU, 64'h80000010, 0, 0, 0, 0, 64'hEF, 0, 0, 0};
    v[11] = '{MC_SH,  64'h80000022, 64'hFFFF1234, 1, 0, 0, 0, 1, 64'h0000FFFF12340000, 8'h0C};
    v[12] = '{MC_LH,  64'h80000022, 0, 0, 0, 0, 64'h1234, 0, 0, 0};
    v[13] = '{MC_SH,  64'h80000021, 64'h55, 0, 0, 1, 0, 0, 0, 0};
    v[14] = '{MC_SW,  64'h80000022, 64'h55, 0, 0, 1, 0, 0, 0, 0};
    v[15] = '{4'b1100, 64'h80000000, 0, 0, 0, 1, 0, 0, 0, 0};
    v[16] = '{MC_LHU, 64'h80000025, 0, 0, 0, 1, 0, 0, 0, 0};
    v[17] = '{MC_LBU, 64'h80000027, 0, 1, 64'hAB00_0000_0000_0000, 0, 64'hAB, 0, 0, 0};
    v[18] = '{MC_LH,  64'h80000010, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_CDEF, 0, 0, 0};
    v[19] = '{MC_SB,  64'h80000032, 64'hFFFFFFFFFFFFFF77, 0, 0, 0, 0, 1, 64'hFFFFFFFFFF770000, 8'h04};
    v[20] = '{MC_LD,  64'h80000030, 0, 0, 0, 0, 64'h0000000000770000, 0, 0, 0};
    #12;
    check("rst_core_ready", {63'b0, core_ready}, 64'd1);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_err", {63'b0, err}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_req_valid", {63'b0, mif.mem_req_valid}, 64'd0);
    check("rst_req_we", {63'b0, mif.mem_req_we}, 64'd0);
    check("rst_req_addr", mif.mem_req_addr, 64'd0);
    check("rst_req_wdata", mif.mem_req_wdata, 64'd0);
    check("rst_req_wmask", {56'b0, mif.mem_req_wmask}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    foreach (v[i]) run(v[i], v[i].err ? 1 : 3, !v[i].err, 1);
    run(v[3], 1, 0, 1);
    @(negedge clk);
    check("ready_after_fault", {63'b0, core_ready}, 64'd1);
    check("no_req_after_fault", {63'b0, mif.mem_req_valid}, 64'd0);
    stall = 5;
    run('{MC_SW, 64'h80000040, 64'h11223344, 0, 0, 0, 0, 1, 64'h11223344, 8'h0F}, 8, 1, 1);
    run('{MC_SB, 64'h80000103, 64'h5A, 0, 0, 0, 0, 1, 64'h5A000000, 8'h08}, 3, 1, 1);
    run('{MC_LBU, 64'h80000103, 0, 0, 0, 0, 64'h5A, 0, 0, 0}, 3, 1, 1);
    silent = 1;
    run('{MC_LHU, 64'h80000202, 0, 0, 0, 1, 0, 0, 0, 0}, 258, 1, 1);
    silent = 0;
    @(negedge clk);
    mif.mem_resp_valid = 1;
    mif.mem_resp_rdata = '1;
    @(negedge clk);
    mif.mem_resp_valid = 0;
    repeat (3) @(negedge clk);
    check("ready_after_late_resp", {63'b0, core_ready}, 64'd1);
    silent = 1;
    run('{MC_SD, 64'h80000300, 64'hCAFEF00D12345678, 0, 0, 0, 0, 1, 64'hCAFEF00D12345678, 8'hFF}, 0, 1, 0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check("arst_core_ready", {63'b0, core_ready}, 64'd1);
    check("arst_done", {63'b0, done}, 64'd0);
    check("arst_err", {63'b0, err}, 64'd0);
    check("arst_rdata", rdata, 64'd0);
    check("arst_req_valid", {63'b0, mif.mem_req_valid}, 64'd0);
    check("arst_req_we", {63'b0, mif.mem_req_we}, 64'd0);
    check("arst_req_addr", mif.mem_req_addr, 64'd0);
    check("arst_req_wdata", mif.mem_req_wdata, 64'd0);
    check("arst_req_wmask", {56'b0, mif.mem_req_wmask}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    silent = 0;
    run(v[6], 3, 1, 1);
    repeat (2) @(negedge clk);
    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
